// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle logic/arith ops plus iterative shift-add multiply and
// restoring divide, with a start/busy/done handshake for pipeline stalls.
module alu_multicycle #(
  parameter int unsigned n = 32,
  parameter int unsigned l = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [l-1:0] ALU_Control,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic         zero,
  output logic         div_by_zero
);

  localparam int unsigned SW = $clog2(n);
  localparam int unsigned CW = $clog2(n);

  localparam logic [l-1:0] OpAdd0 = l'(1);
  localparam logic [l-1:0] OpSub0 = l'(2);
  localparam logic [l-1:0] OpAdd1 = l'(3);
  localparam logic [l-1:0] OpSub1 = l'(4);
  localparam logic [l-1:0] OpMul  = l'(5);
  localparam logic [l-1:0] OpDiv  = l'(6);
  localparam logic [l-1:0] OpOr   = l'(7);
  localparam logic [l-1:0] OpAnd  = l'(8);
  localparam logic [l-1:0] OpXor  = l'(9);
  localparam logic [l-1:0] OpSll  = l'(10);
  localparam logic [l-1:0] OpSrl  = l'(11);
  localparam logic [l-1:0] OpSlt  = l'(12);

  typedef enum logic [1:0] {StIdle, StIter, StFin} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          is_div_q;
  // Shared iteration registers: acc = product/remainder, sh = multiplicand/quotient,
  // opd = multiplier/divisor.
  logic [n-1:0]  acc_q;
  logic [n-1:0]  sh_q;
  logic [n-1:0]  opd_q;

  logic [n-1:0]  single_res;
  logic [n-1:0]  acc_mul;
  logic [n:0]    rem_sh;
  logic [n:0]    diff;
  logic          ge;
  logic [n-1:0]  acc_d;
  logic [n-1:0]  sh_d;
  logic [n-1:0]  opd_d;
  logic [n-1:0]  iter_res;

  always_comb begin
    single_res = '0;
    case (ALU_Control)
      OpAdd0, OpAdd1: single_res = a + b;
      OpSub0, OpSub1: single_res = a - b;
      OpDiv:          single_res = '1;  // only reached with b == 0
      OpOr:           single_res = a | b;
      OpAnd:          single_res = a & b;
      OpXor:          single_res = a ^ b;
      OpSll:          single_res = a << b[SW-1:0];
      OpSrl:          single_res = a >> b[SW-1:0];
      OpSlt:          single_res = {{(n-1){1'b0}}, $signed(a) < $signed(b)};
      default:        single_res = '0;
    endcase
  end

  always_comb begin
    acc_mul = opd_q[0] ? acc_q + sh_q : acc_q;
    rem_sh  = {acc_q, sh_q[n-1]};
    // Top bit of the trial difference is set exactly when the shifted remainder < divisor.
    diff    = rem_sh - {1'b0, opd_q};
    ge      = ~diff[n];
    if (is_div_q) begin
      acc_d    = ge ? diff[n-1:0] : rem_sh[n-1:0];
      sh_d     = {sh_q[n-2:0], ge};
      opd_d    = opd_q;
      iter_res = sh_d;
    end else begin
      acc_d    = acc_mul;
      sh_d     = sh_q << 1;
      opd_d    = opd_q >> 1;
      iter_res = acc_mul;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      acc_q       <= '0;
      sh_q        <= '0;
      opd_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StFin: begin
          state_q <= StIdle;
          if (start) begin
            if (ALU_Control == OpMul || (ALU_Control == OpDiv && b != '0)) begin
              state_q  <= StIter;
              busy     <= 1'b1;
              cnt_q    <= CW'(n - 1);
              is_div_q <= (ALU_Control == OpDiv);
              acc_q    <= '0;
              sh_q     <= a;
              opd_q    <= b;
            end else begin
              result      <= single_res;
              zero        <= (single_res == '0);
              div_by_zero <= (ALU_Control == OpDiv);
              done        <= 1'b1;
            end
          end
        end
        StIter: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          opd_q <= opd_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q     <= StFin;
            busy        <= 1'b0;
            done        <= 1'b1;
            result      <= iter_res;
            zero        <= (iter_res == '0);
            div_by_zero <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus random ops against a
// plain-arithmetic reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(.n(32), .l(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ALU_Control (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] r;
    case (o)
      4'd1, 4'd3: r = x + y;
      4'd2, 4'd4: r = x - y;
      4'd5:       r = x * y;
      4'd6:       r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd7:       r = x | y;
      4'd8:       r = x & y;
      4'd9:       r = x ^ y;
      4'd10:      r = x << y[4:0];
      4'd11:      r = x >> y[4:0];
      4'd12:      r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default:    r = 32'd0;
    endcase
    return r;
  endfunction

  // Issue one op, scramble inputs after acceptance, optionally poke start while busy.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit noise);
    logic [31:0] exp;
    bit long_op;
    bit seen;
    int lat;
    int busy_cnt;
    exp      = model(o, x, y);
    long_op  = (o == 4'd5) || (o == 4'd6 && y != 0);
    seen     = 0;
    lat      = 0;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      a  = $urandom;
      b  = $urandom;
      op = 4'($urandom_range(0, 15));
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        lat  = c;
      end
      start = (busy && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("latency", lat, long_op ? 32'd33 : 32'd1);
    check_eq("busy_cycles", busy_cnt, long_op ? 32'd32 : 32'd0);
    check_eq("result", result, exp);
    check_eq("zero", 32'(zero), 32'(exp == 0));
    check_eq("div_by_zero", 32'(div_by_zero), 32'(o == 4'd6 && y == 0));
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
  endtask

  logic [3:0]  bb_op [5];
  logic [31:0] bb_a  [5];
  logic [31:0] bb_b  [5];

  initial begin
    int dcount;
    logic [31:0] x, y;
    logic [3:0] o;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_zero", 32'(zero), 0);
    check_eq("rst_dbz", 32'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (5) begin
      @(negedge clk);
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_done", 32'(done), 0);
      check_eq("idle_result", result, 0);
      check_eq("idle_zero", 32'(zero), 0);
    end

    // Back-to-back single-cycle ops
    bb_op[0] = 4'd1;  bb_a[0] = 7;             bb_b[0] = 5;
    bb_op[1] = 4'd2;  bb_a[1] = 5;             bb_b[1] = 7;
    bb_op[2] = 4'd12; bb_a[2] = 32'hFFFF_FFFF; bb_b[2] = 1;
    bb_op[3] = 4'd10; bb_a[3] = 1;             bb_b[3] = 31;
    bb_op[4] = 4'd9;  bb_a[4] = 32'hAAAA;      bb_b[4] = 32'hAAAA;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("b2b_done", 32'(done), 1);
        check_eq("b2b_busy", 32'(busy), 0);
        check_eq("b2b_result", result, model(bb_op[i-1], bb_a[i-1], bb_b[i-1]));
        check_eq("b2b_zero", 32'(zero), 32'(model(bb_op[i-1], bb_a[i-1], bb_b[i-1]) == 0));
      end
      if (i < 5) begin
        start = 1'b1; op = bb_op[i]; a = bb_a[i]; b = bb_b[i];
      end else begin
        start = 1'b0;
      end
    end
    check_eq("b2b_sub_value", model(4'd2, 5, 7), 32'hFFFF_FFFE);

    // Directed multiply/divide, with start pokes during busy
    run_op(4'd5, 32'h0001_0003, 32'h0001_0002, 1);
    check_eq("mul_value", result, 32'h0005_0006);
    run_op(4'd6, 100, 7, 1);
    check_eq("div_value", result, 32'd14);
    run_op(4'd6, 5, 0, 0);

    // Reset mid-divide
    @(negedge clk);
    start = 1'b1; op = 4'd6; a = 1000; b = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("mid_busy", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_result", result, 0);
    check_eq("abort_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check_eq("abort_no_done", dcount, 0);
    run_op(4'd1, 2, 2, 0);

    // Unknown code
    run_op(4'd15, 9, 9, 0);
    run_op(4'd0, 3, 4, 0);

    // Random ops
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(0, 31);
      run_op(o, x, y, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
